ball_board: RTL
===============

# ball_board

Clocked, parametrised successor of the board-level ball reserve for the Turing Tumble fabric. Holds one reserve per ball colour and releases one ball per trigger from the bottom of the board. Records the colour of every ball that reaches the bottom into a readable tray, and raises `no_balls` when a requested colour has run out. Sits at the top and bottom edge of the board, between the cell array and the result readout.

## Interface
Parameters:
- `NUM_COLORS`, 2: number of ball colours/channels; colour 0 = blue, 1 = red.
- `BALLS_PER_COLOR`, 8: initial reserve per colour; 1..255.
- `TRAY_DEPTH`, 16: number of tray slots; power of two, ≥2.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `trigger`  in  NUM_COLORS  one-cycle request pulses from the bottom levers.
- `reload`  in  1  synchronous pulse; refills the reserves and empties the tray.
- `ball_out`  out  NUM_COLORS  one-cycle release pulse, one bit per colour.
- `current_color`  out  CW  colour of the ball in play; CW = max(1, $clog2(NUM_COLORS)).
- `in_play`  out  1  a ball is on the board.
- `no_balls`  out  1  sticky: a trigger hit an empty reserve.
- `tray_count`  out  $clog2(TRAY_DEPTH)+1  number of tray slots filled.
- `tray_full`  out  1  `tray_count == TRAY_DEPTH`.
- `tray_overflow`  out  1  sticky: a ball was dropped because the tray was full.
- `multi_trigger`  out  1  sticky: two or more trigger bits were seen in the same cycle.
- `tray_rd_idx`  in  $clog2(TRAY_DEPTH)  tray read address.
- `tray_rd_color`  out  CW  colour stored at `tray_rd_idx`; combinational read.

## Operation
- Reserves: one counter per colour, width $clog2(BALLS_PER_COLOR+1). Each counter resets to BALLS_PER_COLOR.
- Trigger selection: the lowest set index of `trigger` wins. Any other set bits in the same cycle are ignored and set `multi_trigger`.
- States:
  - IDLE: no ball on the board.
  - PLAY: a ball is on the board.
  - HALT: a reserve ran out; `no_balls` = 1.
- IDLE + trigger c:
  - If reserve[c] > 0: decrement it, pulse `ball_out[c]`, set `current_color` = c, go to PLAY.
  - Otherwise: set `no_balls` and go to HALT.
  - Nothing is written to the tray from IDLE.
- PLAY + trigger c:
  - First, the ball in play lands: write `current_color` to tray[tray_count] and increment the count. If the tray is full, do not write; set `tray_overflow` instead.
  - Then, if reserve[c] > 0: decrement it, pulse `ball_out[c]`, set `current_color` = c, stay in PLAY.
  - Otherwise: set `no_balls`, clear `in_play`, go to HALT; `current_color` holds its value.
- HALT: triggers are ignored. `ball_out` stays 0 and the tray does not change.
- `reload` has priority over `trigger` in the same cycle. It:
  - restores all reserves to BALLS_PER_COLOR;
  - sets `tray_count` = 0;
  - clears `no_balls`, `tray_overflow` and `multi_trigger`;
  - goes to IDLE.
  - Tray contents are not cleared; they are stale data.
- Arithmetic: reserves never underflow; `tray_count` saturates at TRAY_DEPTH.

## Timing
- Trigger sampled at edge t:
  - `ball_out`, reserves, `current_color`, `in_play` and the state update at t. Outputs are registered and visible during cycle t..t+1.
  - `ball_out` is high for exactly one cycle.
- A tray write and its `tray_count` increment land on the same edge. `tray_rd_color` at the new address is valid in the following cycle.
- Back-to-back triggers on consecutive cycles are fully supported; one ball is processed per cycle.
- Reset values:
  - state IDLE;
  - `ball_out` 0, `current_color` 0, `in_play` 0;
  - `no_balls` 0, `tray_count` 0, `tray_full` 0, `tray_overflow` 0, `multi_trigger` 0;
  - reserves = BALLS_PER_COLOR.
  - Tray storage is not reset.
- Reset asserted mid-operation forces the above asynchronously. The first edge after deassertion behaves as IDLE.

## Structure
- Shared package `tt_pkg`:
  - colour constants `TT_BLUE` = 0, `TT_RED` = 1;
  - state enum `board_state_t` {IDLE, PLAY, HALT};
  - function `tt_color_w(n)`.
- Sub-module `ball_tray`: a TRAY_DEPTH×CW register file with a write pointer, saturating count, full/overflow flags and a combinational read port.
- The reserve counters are a generate loop in the top module.

## Test plan
- Reset, then trigger[0] → `ball_out` = 01 for one cycle, `in_play` = 1, `current_color` = 0, `tray_count` = 0, reserve0 = 7.
- Alternate triggers 1,0,1 on consecutive cycles after the first ball → `tray_count` = 3, tray[0..2] = 0,1,0, `current_color` = 1.
- Reserves of 8 each, 9 triggers on colour 0 → the 9th gives no `ball_out`, `no_balls` = 1, HALT, `tray_count` = 8. A further trigger[1] is ignored.
- TRAY_DEPTH = 4, 6 triggers → `tray_full` = 1 after the 5th trigger, `tray_overflow` = 1 after the 6th, `tray_count` stays at 4.
- trigger = 11 in one cycle from IDLE → `ball_out` = 01 only, `multi_trigger` = 1, reserve1 unchanged at 8.
- `reload` together with a trigger in HALT → IDLE, all flags clear, reserves 8/8, no `ball_out`. Assert `rst_n` low mid-PLAY → outputs take their reset values immediately, without a clock edge.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared definitions for the Turing Tumble board blocks: colour codes,
// board state encoding and the colour-width helper.
package tt_pkg;

    localparam int TT_BLUE = 0;
    localparam int TT_RED  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HALT = 2'd2
    } board_state_t;

    // Width of a colour code; at least one bit even for a single colour.
    function automatic int tt_color_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ball_tray.sv
// Tray of landed balls: register file written at the fill pointer,
// saturating fill count, full/overflow flags, combinational read port.
module ball_tray #(
    parameter int DEPTH = 16,
    parameter int CW    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [CW-1:0]          wr_color,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [CW-1:0]          rd_color
);
    localparam int AW = $clog2(DEPTH);

    // Storage is deliberately left unreset; slots beyond count are stale.
    logic [CW-1:0] mem [DEPTH];

    assign full     = (count == (AW+1)'(DEPTH));
    assign rd_color = mem[rd_idx];

    // Fill count and overflow flag; count doubles as the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (wr_en) begin
            if (full) overflow <= 1'b1;
            else      count    <= count + 1'b1;
        end
    end

    // Write the landed colour into the next free slot.
    always_ff @(posedge clk) begin
        if (wr_en && !clr && !full)
            mem[count[AW-1:0]] <= wr_color;
    end

endmodule

// File: rtl/ball_board.sv
// Board-level ball reserve: per-colour reserves, one release per trigger,
// landed-ball tray and sticky error flags.
module ball_board
    import tt_pkg::*;
#(
    parameter int NUM_COLORS      = 2,
    parameter int BALLS_PER_COLOR = 8,
    parameter int TRAY_DEPTH      = 16,
    localparam int CW = tt_color_w(NUM_COLORS),
    localparam int AW = $clog2(TRAY_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_COLORS-1:0] trigger,
    input  logic                  reload,
    output logic [NUM_COLORS-1:0] ball_out,
    output logic [CW-1:0]         current_color,
    output logic                  in_play,
    output logic                  no_balls,
    output logic [AW:0]           tray_count,
    output logic                  tray_full,
    output logic                  tray_overflow,
    output logic                  multi_trigger,
    input  logic [AW-1:0]         tray_rd_idx,
    output logic [CW-1:0]         tray_rd_color
);
    localparam int RW = $clog2(BALLS_PER_COLOR + 1);

    board_state_t state_q, state_d;

    logic [RW-1:0]         reserve [NUM_COLORS];
    logic [NUM_COLORS-1:0] has_ball;
    logic [NUM_COLORS-1:0] grant;
    logic [CW-1:0]         sel;
    logic                  any_trig, multi_seen, avail;
    logic                  release_ball, land, go_halt;

    // Lowest set trigger bit wins; extra bits only flag multi_trigger.
    assign any_trig   = |trigger;
    assign grant      = trigger & (~trigger + 1'b1);
    assign multi_seen = |(trigger & (trigger - 1'b1));
    assign avail      = |(grant & has_ball);

    // Encode the winning trigger index.
    always_comb begin
        sel = '0;
        for (int i = NUM_COLORS - 1; i >= 0; i--)
            if (trigger[i]) sel = CW'(i);
    end

    // Per-colour reserve counters; never decremented at zero.
    for (genvar g = 0; g < NUM_COLORS; g++) begin : g_reserve
        assign has_ball[g] = (reserve[g] != '0);

        // Refill on reload, decrement on a release of this colour.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                reserve[g] <= RW'(BALLS_PER_COLOR);
            else if (reload)
                reserve[g] <= RW'(BALLS_PER_COLOR);
            else if (release_ball && grant[g] && has_ball[g])
                reserve[g] <= reserve[g] - 1'b1;
        end
    end

    // Board state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state plus release/land/halt decisions; reload overrides triggers.
    always_comb begin
        state_d      = state_q;
        release_ball = 1'b0;
        land         = 1'b0;
        go_halt      = 1'b0;
        if (reload) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, PLAY: begin
                    if (any_trig) begin
                        land = (state_q == PLAY);
                        if (avail) begin
                            release_ball = 1'b1;
                            state_d      = PLAY;
                        end else begin
                            go_halt = 1'b1;
                            state_d = HALT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ball_out      <= '0;
            current_color <= '0;
            no_balls      <= 1'b0;
            multi_trigger <= 1'b0;
        end else begin
            ball_out <= release_ball ? grant : '0;
            if (release_ball) current_color <= sel;
            if (reload)       no_balls <= 1'b0;
            else if (go_halt) no_balls <= 1'b1;
            if (reload)
                multi_trigger <= 1'b0;
            else if (multi_seen && state_q != HALT)
                multi_trigger <= 1'b1;
        end
    end

    assign in_play = (state_q == PLAY);

    ball_tray #(
        .DEPTH (TRAY_DEPTH),
        .CW    (CW)
    ) u_tray (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (reload),
        .wr_en    (land),
        .wr_color (current_color),
        .count    (tray_count),
        .full     (tray_full),
        .overflow (tray_overflow),
        .rd_idx   (tray_rd_idx),
        .rd_color (tray_rd_color)
    );

endmodule
